// File: rtl/qeciphy_tx_packetiser.sv
// ---------------------------------------------------------------------------
// qeciphy_tx_packetiser
// Builds the transmit word stream from the TX boundary flags and an upstream
// valid/ready payload stream. Every clock cycle is one slot:
//   FAW slot  -> FAW_PATTERN                     (type 11)
//   CRC slot  -> CRC-16 of the preceding 6 data slots (type 10)
//   data slot -> popped payload (type 01) or IDLE_PATTERN fill (type 00)
// The block also polices the boundary flags. Any illegal combination drops
// the block back to WAIT and sets a sticky error flag.
//
// Ports
//   clk_i                 clock
//   rst_i                 synchronous reset, active-high
//   faw_boundary_i        current slot is FAW
//   almost_faw_boundary_i next slot is FAW
//   crc_boundary_i        current slot is CRC
//   data_i/data_valid_i   upstream payload and valid
//   data_ready_o          payload popped this cycle when valid & ready
//   tx_word_o/tx_type_o   registered transmit word and its type
//   tx_valid_o            1 in every cycle after reset
//   locked_o              framing FSM is in RUN
//   protocol_err_o        sticky boundary-protocol violation
// ---------------------------------------------------------------------------
module qeciphy_tx_packetiser #(
   parameter int          DATA_W       = 64,
   parameter logic [63:0] FAW_PATTERN  = 64'hF6F6_F628_2828_A5C3,
   parameter logic [63:0] IDLE_PATTERN = 64'h0707_0707_0707_0707,
   parameter logic [15:0] CRC_INIT     = 16'hFFFF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              faw_boundary_i,
   input  logic              almost_faw_boundary_i,
   input  logic              crc_boundary_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_valid_i,
   output logic              data_ready_o,
   output logic [DATA_W-1:0] tx_word_o,
   output logic [1:0]        tx_type_o,
   output logic              tx_valid_o,
   output logic              locked_o,
   output logic              protocol_err_o
);

   localparam logic [DATA_W-1:0] FAW_W  = FAW_PATTERN[DATA_W-1:0];
   localparam logic [DATA_W-1:0] IDLE_W = IDLE_PATTERN[DATA_W-1:0];

   typedef enum logic [0:0] {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_r;
   logic [15:0]       crc_r;
   logic [2:0]        slot_cnt_r;
   logic              prev_almost_r;
   logic [DATA_W-1:0] tx_word_r;
   logic [1:0]        tx_type_r;
   logic              tx_valid_r;
   logic              protocol_err_r;

   logic              slot_data_s;
   logic              err_now_s;
   logic [DATA_W-1:0] data_word_s;
   logic [15:0]       crc_next_s;

   // CRC-16 (poly 0x1021), word MSB first, fully unrolled into one cycle
   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                              input logic [DATA_W-1:0] word);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = c[15] ^ word[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   assign slot_data_s = !faw_boundary_i && !crc_boundary_i;
   assign data_word_s = data_valid_i ? data_i : IDLE_W;
   assign crc_next_s  = crc16_word(crc_r, data_word_s);

   // Boundary-flag legality while framing; a frame is FAW/CRC then 6 data slots
   always_comb begin
      err_now_s = 1'b0;
      if (state_r == ST_RUN) begin
         err_now_s = (faw_boundary_i && crc_boundary_i)
                  || (faw_boundary_i && !prev_almost_r)
                  || (crc_boundary_i && (slot_cnt_r != 3'd6))
                  || (faw_boundary_i && (slot_cnt_r != 3'd0))
                  || (slot_data_s && (slot_cnt_r == 3'd6));
      end else begin
         err_now_s = 1'b0;
      end
   end

   // Pop only in a legal data slot; a reset cycle never consumes the pending word
   assign data_ready_o = !rst_i && (state_r == ST_RUN) && slot_data_s && !err_now_s;

   // Framing FSM, CRC accumulator and registered transmit outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= ST_WAIT;
         crc_r          <= CRC_INIT;
         slot_cnt_r     <= 3'd0;
         prev_almost_r  <= 1'b0;
         tx_word_r      <= IDLE_W;
         tx_type_r      <= 2'b00;
         tx_valid_r     <= 1'b0;
         protocol_err_r <= 1'b0;
      end else begin
         prev_almost_r <= almost_faw_boundary_i;
         tx_valid_r    <= 1'b1;
         case (state_r)
            ST_WAIT: begin
               if (faw_boundary_i && prev_almost_r) begin
                  state_r    <= ST_RUN;
                  tx_word_r  <= FAW_W;
                  tx_type_r  <= 2'b11;
                  crc_r      <= CRC_INIT;
                  slot_cnt_r <= 3'd0;
               end else begin
                  tx_word_r  <= IDLE_W;
                  tx_type_r  <= 2'b00;
               end
            end
            ST_RUN: begin
               if (err_now_s) begin
                  state_r        <= ST_WAIT;
                  tx_word_r      <= IDLE_W;
                  tx_type_r      <= 2'b00;
                  protocol_err_r <= 1'b1;
                  crc_r          <= CRC_INIT;
                  slot_cnt_r     <= 3'd0;
               end else if (faw_boundary_i) begin
                  tx_word_r  <= FAW_W;
                  tx_type_r  <= 2'b11;
                  crc_r      <= CRC_INIT;
                  slot_cnt_r <= 3'd0;
               end else if (crc_boundary_i) begin
                  tx_word_r  <= {{(DATA_W-16){1'b0}}, crc_r};
                  tx_type_r  <= 2'b10;
                  crc_r      <= CRC_INIT;
                  slot_cnt_r <= 3'd0;
               end else begin
                  // IDLE fills are covered by the CRC exactly as transmitted
                  tx_word_r  <= data_word_s;
                  tx_type_r  <= {1'b0, data_valid_i};
                  crc_r      <= crc_next_s;
                  slot_cnt_r <= (slot_cnt_r == 3'd7) ? 3'd7 : slot_cnt_r + 3'd1;
               end
            end
            default: begin
               state_r   <= ST_WAIT;
               tx_word_r <= IDLE_W;
               tx_type_r <= 2'b00;
            end
         endcase
      end
   end

   assign tx_word_o      = tx_word_r;
   assign tx_type_o      = tx_type_r;
   assign tx_valid_o     = tx_valid_r;
   assign locked_o       = (state_r == ST_RUN);
   assign protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_qeciphy_tx_packetiser.sv
module tb_qeciphy_tx_packetiser;

   localparam logic [63:0] FAW  = 64'hF6F6_F628_2828_A5C3;
   localparam logic [63:0] IDLE = 64'h0707_0707_0707_0707;

   typedef logic [63:0] word_q_t[$];

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        faw_boundary_i = 1'b0;
   logic        almost_faw_boundary_i = 1'b0;
   logic        crc_boundary_i = 1'b0;
   logic [63:0] data_i = 64'd0;
   logic        data_valid_i = 1'b0;
   logic        data_ready_o;
   logic [63:0] tx_word_o;
   logic [1:0]  tx_type_o;
   logic        tx_valid_o;
   logic        locked_o;
   logic        protocol_err_o;

   int tests = 0;
   int fails = 0;

   // reference model state: framing flag, sticky error, previous almost, words of current frame
   logic        m_locked = 1'b0;
   logic        m_err = 1'b0;
   logic        m_prev = 1'b0;
   word_q_t     m_q;
   logic        exp_valid, exp_locked, exp_err, exp_ready;
   logic [1:0]  exp_type;
   logic [63:0] exp_word;
   logic        obs_ready;
   logic [69:0] got_v, exp_v;
   logic [63:0] pay = 64'd1;

   qeciphy_tx_packetiser dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .faw_boundary_i        (faw_boundary_i),
      .almost_faw_boundary_i (almost_faw_boundary_i),
      .crc_boundary_i        (crc_boundary_i),
      .data_i                (data_i),
      .data_valid_i          (data_valid_i),
      .data_ready_o          (data_ready_o),
      .tx_word_o             (tx_word_o),
      .tx_type_o             (tx_type_o),
      .tx_valid_o            (tx_valid_o),
      .locked_o              (locked_o),
      .protocol_err_o        (protocol_err_o)
   );

   always #5 clk_i = ~clk_i;

   // CRC-16/0x1021 over a list of 64-bit words, bit 63 of each word first
   function automatic logic [15:0] crc_ref(input word_q_t ws);
      logic [15:0] c = 16'hFFFF;
      foreach (ws[k]) begin
         for (int b = 63; b >= 0; b--) begin
            if (c[15] ^ ws[k][b]) c = (c << 1) ^ 16'h1021;
            else                  c = c << 1;
         end
      end
      return c;
   endfunction

   // Expected behaviour of one slot from the protocol rules
   task automatic m_step();
      int   n;
      logic bad;
      exp_ready = 1'b0;
      exp_word  = IDLE;
      exp_type  = 2'b00;
      if (rst_i) begin
         m_locked = 1'b0; m_err = 1'b0; m_prev = 1'b0; m_q.delete();
         exp_valid = 1'b0;
      end else begin
         exp_valid = 1'b1;
         if (!m_locked) begin
            if (faw_boundary_i && m_prev) begin
               m_locked = 1'b1; exp_word = FAW; exp_type = 2'b11; m_q.delete();
            end
         end else begin
            n   = m_q.size();
            bad = (faw_boundary_i && crc_boundary_i) || (faw_boundary_i && !m_prev)
               || (crc_boundary_i && n != 6) || (faw_boundary_i && n != 0)
               || (!faw_boundary_i && !crc_boundary_i && n == 6);
            if (bad) begin
               m_err = 1'b1; m_locked = 1'b0;
            end else if (faw_boundary_i) begin
               exp_word = FAW; exp_type = 2'b11; m_q.delete();
            end else if (crc_boundary_i) begin
               exp_word = {48'd0, crc_ref(m_q)}; exp_type = 2'b10; m_q.delete();
            end else begin
               exp_ready = 1'b1;
               if (data_valid_i) begin
                  exp_word = data_i; exp_type = 2'b01;
               end
               m_q.push_back(exp_word);
            end
         end
         m_prev = almost_faw_boundary_i;
      end
      exp_locked = m_locked;
      exp_err    = m_err;
   endtask

   // Drive one slot (code = {faw, almost, crc}), sample ready mid-cycle, land 1 after the edge
   task automatic drive(input logic r, input logic [2:0] code, input logic v);
      rst_i = r;
      {faw_boundary_i, almost_faw_boundary_i, crc_boundary_i} = code;
      data_valid_i = v;
      data_i = pay;
      #1;
      m_step();
      #2 obs_ready = data_ready_o;
      @(posedge clk_i);
      #1;
      if (obs_ready && v) pay = pay + 64'd1;
      got_v = {tx_valid_o, tx_type_o, tx_word_o, locked_o, protocol_err_o, obs_ready};
      exp_v = {exp_valid, exp_type, exp_word, exp_locked, exp_err, exp_ready};
   endtask

   // 9 x (6 data + CRC), almost raised on the last CRC slot, then the next FAW
   function automatic void frame_seq(ref logic [2:0] q[$]);
      for (int i = 0; i < 63; i++)
         q.push_back((i % 7 == 6) ? ((i == 62) ? 3'b011 : 3'b001) : 3'b000);
      q.push_back(3'b100);
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'b000, 1'b1);
         tests++;
         if (got_v !== {1'b0, 2'b00, IDLE, 3'b000}) begin
            fails++; $display("FAIL reset_values got %h exp %h", got_v, {1'b0, 2'b00, IDLE, 3'b000});
         end
      end
   endtask

   task automatic test_counter_frames();
      logic [2:0] q[$];
      word_q_t    ref6;
      int         c = 0;
      pay = 64'd1;
      for (int i = 1; i <= 6; i++) ref6.push_back(64'(i));
      for (int i = 0; i < 4; i++) q.push_back(3'b000);
      q.push_back(3'b010);
      q.push_back(3'b100);
      frame_seq(q);
      foreach (q[i]) begin
         drive(1'b0, q[i], 1'b1);
         c++;
         tests++;
         if (got_v !== exp_v) begin
            fails++; $display("FAIL t1_slot%0d got %h exp %h", c, got_v, exp_v);
         end
         if (c == 6 || c == 70) begin
            tests++;
            if (tx_type_o !== 2'b11 || tx_word_o !== FAW) begin
               fails++; $display("FAIL t1_faw_at_%0d got %b/%h exp 11/%h", c + 1, tx_type_o, tx_word_o, FAW);
            end
         end
         if (c == 7) begin
            tests++;
            if (tx_word_o !== 64'd1 || tx_type_o !== 2'b01) begin
               fails++; $display("FAIL t1_first_data got %h exp 1", tx_word_o);
            end
         end
         if (c == 13) begin
            tests++;
            if (tx_word_o !== {48'd0, crc_ref(ref6)} || tx_type_o !== 2'b10) begin
               fails++; $display("FAIL t1_crc got %h exp %h", tx_word_o, crc_ref(ref6));
            end
         end
      end
   endtask

   task automatic test_idle_frames();
      logic [2:0] q[$];
      word_q_t    idle6;
      int         idles = 0;
      for (int i = 0; i < 6; i++) idle6.push_back(IDLE);
      frame_seq(q);
      foreach (q[i]) begin
         drive(1'b0, q[i], 1'b0);
         tests++;
         if (got_v !== exp_v) begin
            fails++; $display("FAIL t2_slot%0d got %h exp %h", i, got_v, exp_v);
         end
         if (tx_type_o === 2'b00) idles++;
         if (q[i][0]) begin
            tests++;
            if (tx_word_o !== {48'd0, crc_ref(idle6)}) begin
               fails++; $display("FAIL t2_idle_crc got %h exp %h", tx_word_o, crc_ref(idle6));
            end
         end
      end
      tests++;
      if (idles != 54) begin
         fails++; $display("FAIL t2_idle_count got %0d exp 54", idles);
      end
   endtask

   task automatic test_faw_no_almost();
      logic [2:0] q[$] = '{3'b000, 3'b100, 3'b000, 3'b100};
      drive(1'b1, 3'b000, 1'b0);
      foreach (q[i]) begin
         drive(1'b0, q[i], $urandom_range(0, 1));
         tests++;
         if (got_v !== exp_v || locked_o !== 1'b0 || protocol_err_o !== 1'b0 || tx_type_o !== 2'b00) begin
            fails++; $display("FAIL t3_wait%0d got %h exp %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_early_crc();
      logic [2:0] q[$] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
      logic [63:0] pay_before;
      pay = 64'($urandom);
      foreach (q[i]) begin
         pay_before = pay;
         drive(1'b0, q[i], 1'b1);
         tests++;
         if (got_v !== exp_v) begin
            fails++; $display("FAIL t4_slot%0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 7) begin
            tests++;
            if (protocol_err_o !== 1'b1 || locked_o !== 1'b0 || tx_type_o !== 2'b00
                || tx_word_o !== IDLE || obs_ready !== 1'b0 || pay !== pay_before) begin
               fails++; $display("FAIL t4_err got e%b l%b t%b r%b exp e1 l0 t00 r0",
                                 protocol_err_o, locked_o, tx_type_o, obs_ready);
            end
         end
      end
   endtask

   task automatic test_faw_crc_together();
      logic [2:0] q[$] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b101, 3'b000, 3'b010, 3'b100, 3'b000};
      foreach (q[i]) begin
         drive(1'b0, q[i], $urandom_range(0, 1));
         pay = 64'($urandom);
         tests++;
         if (got_v !== exp_v) begin
            fails++; $display("FAIL t5_slot%0d got %h exp %h", i, got_v, exp_v);
         end
         if (i == 4) begin
            tests++;
            if (locked_o !== 1'b0 || tx_type_o !== 2'b00 || obs_ready !== 1'b0) begin
               fails++; $display("FAIL t5_err got l%b t%b r%b exp l0 t00 r0", locked_o, tx_type_o, obs_ready);
            end
         end
         if (i == 7) begin
            tests++;
            if (locked_o !== 1'b1 || protocol_err_o !== 1'b1 || tx_type_o !== 2'b11) begin
               fails++; $display("FAIL t5_relock got l%b e%b t%b exp l1 e1 t11", locked_o, protocol_err_o, tx_type_o);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [2:0] q[$] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
      logic [63:0] pay_before;
      drive(1'b1, 3'b000, 1'b0);
      drive(1'b0, 3'b010, 1'b0);
      drive(1'b0, 3'b100, 1'b0);
      drive(1'b0, 3'b000, 1'b1);
      drive(1'b0, 3'b000, 1'b1);
      pay_before = pay;
      drive(1'b1, 3'b000, 1'b1);
      tests++;
      if (got_v !== {1'b0, 2'b00, IDLE, 3'b000} || pay !== pay_before) begin
         fails++; $display("FAIL t6_reset_mid got %h exp %h", got_v, {1'b0, 2'b00, IDLE, 3'b000});
      end
      foreach (q[i]) begin
         drive(1'b0, q[i], 1'b1);
         tests++;
         if (got_v !== exp_v) begin
            fails++; $display("FAIL t6_relock%0d got %h exp %h", i, got_v, exp_v);
         end
      end
      tests++;
      if (locked_o !== 1'b1 || protocol_err_o !== 1'b0) begin
         fails++; $display("FAIL t6_locked got l%b e%b exp l1 e0", locked_o, protocol_err_o);
      end
   endtask

   initial begin
      @(posedge clk_i);
      #1;
      test_reset();
      test_counter_frames();
      test_idle_frames();
      test_faw_no_almost();
      test_early_crc();
      test_faw_crc_together();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
